mem_port_arbiter: RTL and testbench

//   Shares the single-port unified memory between instruction fetch (IF) and load/store unit (LS).

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-macro signals around
// mem_port_arbiter.
//   if_*   : instruction fetch request / grant / response
//   ls_*   : load/store request / grant / response
//   mem_*  : single-port memory macro strobe, write controls and read data
// Modports:
//   master : the side that drives requests and memory read data
//            (core datapath plus memory macro)
//   slave  : the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [BE_W-1:0]   ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares a single-port unified memory between instruction fetch (IF) and
// the load/store unit (LS). One transaction is outstanding at a time; LS has
// priority, except that after MAX_STALL consecutive LS wins against a
// pending fetch the fetch is served.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of mem_port_arbiter_if (if_*, ls_*, mem_* signals)
// Transaction timeline (T = cycle in which requests are sampled):
//   T+1 ISSUE : mem_* driven, winner's gnt pulse
//   WAIT      : MEM_LAT cycles, read data captured in the last one
//   RESP      : winner's rvalid pulse; requests sampled again here
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_STALL = 4
) (
    input logic             clk,
    input logic             rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [2:0] LAT_LAST  = 3'(MEM_LAT - 1);
    localparam logic [3:0] STALL_MAX = 4'(MAX_STALL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [2:0]        lat_r;
    logic [3:0]        stall_r;
    logic [3:0]        stall_nxt_s;
    logic              owner_ls_r;
    logic              owner_we_r;
    logic              sample_s;
    logic              any_req_s;
    logic              pick_ls_s;
    logic              wait_done_s;

    logic              if_gnt_r;
    logic              if_rvalid_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic              ls_gnt_r;
    logic              ls_rvalid_r;
    logic [DATA_W-1:0] ls_rdata_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [BE_W-1:0]   mem_be_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    // Arbitration decision and anti-starvation counter update.
    always_comb begin
        sample_s    = (state_r == ST_IDLE) || (state_r == ST_RESP);
        any_req_s   = bus.if_req || bus.ls_req;
        wait_done_s = (lat_r == LAT_LAST);
        pick_ls_s   = 1'b0;
        stall_nxt_s = 4'd0;
        if (bus.ls_req && bus.if_req) begin
            pick_ls_s = (stall_r != STALL_MAX);
        end else begin
            pick_ls_s = bus.ls_req;
        end
        // Only LS wins against a waiting fetch advance the counter.
        if (pick_ls_s && bus.if_req) begin
            stall_nxt_s = (stall_r == STALL_MAX) ? stall_r : (stall_r + 4'd1);
        end else begin
            stall_nxt_s = 4'd0;
        end
    end

    // Next-state logic of the transaction sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = any_req_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT:  state_s = wait_done_s ? ST_RESP : ST_WAIT;
            ST_RESP:  state_s = any_req_s ? ST_ISSUE : ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered grant, memory strobe, response capture and bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_r       <= 3'd0;
            stall_r     <= 4'd0;
            owner_ls_r  <= 1'b0;
            owner_we_r  <= 1'b0;
            if_gnt_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            if_rdata_r  <= '0;
            ls_gnt_r    <= 1'b0;
            ls_rvalid_r <= 1'b0;
            ls_rdata_r  <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            // Pulses and memory fields are only ever one cycle wide.
            if_gnt_r    <= 1'b0;
            ls_gnt_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            ls_rvalid_r <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_be_r    <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;

            if (sample_s && any_req_s) begin
                stall_r    <= stall_nxt_s;
                owner_ls_r <= pick_ls_s;
                mem_en_r   <= 1'b1;
                if (pick_ls_s) begin
                    owner_we_r  <= bus.ls_we;
                    ls_gnt_r    <= 1'b1;
                    mem_we_r    <= bus.ls_we;
                    mem_be_r    <= bus.ls_we ? bus.ls_be : {BE_W{1'b1}};
                    mem_addr_r  <= bus.ls_addr;
                    mem_wdata_r <= bus.ls_we ? bus.ls_wdata : {DATA_W{1'b0}};
                end else begin
                    owner_we_r  <= 1'b0;
                    if_gnt_r    <= 1'b1;
                    mem_be_r    <= {BE_W{1'b1}};
                    mem_addr_r  <= bus.if_addr;
                end
            end

            if (state_r == ST_ISSUE) begin
                lat_r <= 3'd0;
            end else if (state_r == ST_WAIT) begin
                lat_r <= lat_r + 3'd1;
            end

            // Last WAIT cycle: memory data is valid now, present it next cycle.
            if ((state_r == ST_WAIT) && wait_done_s) begin
                if (owner_ls_r) begin
                    ls_rvalid_r <= 1'b1;
                    ls_rdata_r  <= owner_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
                end else begin
                    if_rvalid_r <= 1'b1;
                    if_rdata_r  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt_r;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.ls_gnt    = ls_gnt_r;
    assign bus.ls_rvalid = ls_rvalid_r;
    assign bus.ls_rdata  = ls_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_be    = mem_be_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A (MEM_LAT=1, MAX_STALL=4) is checked
// every cycle against a transaction-schedule model; instance B (MEM_LAT=3)
// covers back-to-back fetch spacing with directed checks.
module tb_mem_port_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MAXS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A), .MAX_STALL(MAXS))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B), .MAX_STALL(MAXS))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Read-only memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory macros: data valid MEM_LAT cycles after the strobe cycle.
    logic [31:0] pa;
    logic [31:0] pb [3];
    always @(posedge clk) begin
        pa    <= ifa.mem_addr;
        pb[0] <= ifb.mem_addr;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign ifa.mem_rdata = mem_word(pa);
    assign ifb.mem_rdata = mem_word(pb[2]);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-schedule model of instance A.
    int          m_free = 0;
    int          m_iss  = -1;
    int          m_rv   = -1;
    int          m_stall = 0;
    bit          m_own_ls = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [3:0]  m_be = 4'h0;
    logic [31:0] m_if_rd = 32'h0;
    logic [31:0] m_ls_rd = 32'h0;
    bit          e_en;
    bit          e_rv;

    // Per-cycle comparison of every instance-A output against the model.
    always @(negedge clk) begin
        if (rst) begin
            m_iss = -1; m_rv = -1; m_stall = 0;
            m_if_rd = 32'h0; m_ls_rd = 32'h0;
            m_free = cyc + 1;
        end
        e_en = (m_iss == cyc);
        e_rv = (m_rv == cyc);
        if (e_rv) begin
            if (m_own_ls) m_ls_rd = m_we ? 32'h0 : mem_word(m_addr);
            else          m_if_rd = mem_word(m_addr);
        end
        chk("if_gnt",    {31'h0, ifa.if_gnt},    {31'h0, e_en && !m_own_ls});
        chk("ls_gnt",    {31'h0, ifa.ls_gnt},    {31'h0, e_en && m_own_ls});
        chk("mem_en",    {31'h0, ifa.mem_en},    {31'h0, e_en});
        chk("mem_we",    {31'h0, ifa.mem_we},    {31'h0, e_en && m_we});
        chk("mem_be",    {28'h0, ifa.mem_be},    e_en ? {28'h0, m_be} : 32'h0);
        chk("mem_addr",  ifa.mem_addr,           e_en ? m_addr : 32'h0);
        chk("mem_wdata", ifa.mem_wdata,          e_en ? m_wdata : 32'h0);
        chk("if_rvalid", {31'h0, ifa.if_rvalid}, {31'h0, e_rv && !m_own_ls});
        chk("ls_rvalid", {31'h0, ifa.ls_rvalid}, {31'h0, e_rv && m_own_ls});
        chk("if_rdata",  ifa.if_rdata,           m_if_rd);
        chk("ls_rdata",  ifa.ls_rdata,           m_ls_rd);
        if (!rst && cyc >= m_free && (ifa.if_req || ifa.ls_req)) begin
            if (ifa.ls_req && !(ifa.if_req && m_stall == MAXS)) begin
                m_own_ls = 1'b1;
                m_we     = ifa.ls_we;
                m_addr   = ifa.ls_addr;
                m_be     = ifa.ls_we ? ifa.ls_be : 4'hF;
                m_wdata  = ifa.ls_we ? ifa.ls_wdata : 32'h0;
                m_stall  = ifa.if_req ? ((m_stall < MAXS) ? m_stall + 1 : MAXS) : 0;
            end else begin
                m_own_ls = 1'b0;
                m_we     = 1'b0;
                m_addr   = ifa.if_addr;
                m_be     = 4'hF;
                m_wdata  = 32'h0;
                m_stall  = 0;
            end
            m_iss  = cyc + 1;
            m_rv   = cyc + LAT_A + 2;
            m_free = m_rv;
        end
    end

    // Instance B response log.
    int          nrv = 0;
    int          rvc [3];
    logic [31:0] rvd [3];
    always @(negedge clk) begin
        if (ifb.if_rvalid && nrv < 3) begin
            rvc[nrv] = cyc;
            rvd[nrv] = ifb.if_rdata;
            nrv++;
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0:       return ifa.if_gnt;
            1:       return ifa.ls_gnt;
            2:       return ifa.if_rvalid;
            3:       return ifa.ls_rvalid;
            4:       return ifb.if_gnt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_%0d: event not seen, required within 40 cycles", which);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: run did not finish, required end before 100000");
        $fatal(1, "timeout");
    end

    int t0, tg, tr, cnt, ng;
    logic [9:0] seq;
    int g [3];

    initial begin
        ifa.if_req = 1'b0; ifa.if_addr = 32'h0;
        ifa.ls_req = 1'b0; ifa.ls_we = 1'b0; ifa.ls_be = 4'h0;
        ifa.ls_addr = 32'h0; ifa.ls_wdata = 32'h0;
        ifb.if_req = 1'b0; ifb.if_addr = 32'h0;
        ifb.ls_req = 1'b0; ifb.ls_we = 1'b0; ifb.ls_be = 4'h0;
        ifb.ls_addr = 32'h0; ifb.ls_wdata = 32'h0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_mem_en", {31'h0, ifa.mem_en}, 32'h0);
        chk("reset_rdata",  ifa.if_rdata, 32'h0);
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // 1: single fetch
        ifa.if_addr = 32'h10; ifa.if_req = 1'b1; t0 = cyc;
        wait_for(0, tg);
        chk("t1_gnt_cycle", tg, t0 + 1);
        chk("t1_mem_addr", ifa.mem_addr, 32'h10);
        step(); ifa.if_req = 1'b0;
        wait_for(2, tr);
        chk("t1_rvalid_cycle", tr, t0 + 3);
        chk("t1_rdata", ifa.if_rdata, 32'hDEADBEEF);

        // 2: simultaneous IF and LS load
        step();
        ifa.if_addr = 32'h24; ifa.if_req = 1'b1;
        ifa.ls_addr = 32'h200; ifa.ls_we = 1'b0; ifa.ls_req = 1'b1; t0 = cyc;
        wait_for(1, tg);
        chk("t2_ls_gnt_cycle", tg, t0 + 1);
        chk("t2_ls_addr", ifa.mem_addr, 32'h200);
        step(); ifa.ls_req = 1'b0;
        wait_for(0, tg);
        chk("t2_if_gnt_cycle", tg, t0 + 4);
        step(); ifa.if_req = 1'b0;
        wait_for(2, tr);
        chk("t2_if_rvalid_cycle", tr, t0 + 6);

        // 3: both held high -> LS x4, IF, LS x4, IF
        step();
        ifa.if_addr = 32'h20; ifa.ls_addr = 32'h300;
        ifa.if_req = 1'b1; ifa.ls_req = 1'b1;
        seq = 10'h0; ng = 0;
        for (int i = 0; i < 80 && ng < 10; i++) begin
            @(negedge clk);
            if (ifa.if_gnt) begin seq[ng] = 1'b1; ng++; end
            else if (ifa.ls_gnt) ng++;
        end
        step(); ifa.if_req = 1'b0; ifa.ls_req = 1'b0;
        chk("t3_grant_count", ng, 10);
        chk("t3_grant_order", {22'h0, seq}, 32'h210);
        repeat (5) step();

        // 4: store
        ifa.ls_we = 1'b1; ifa.ls_be = 4'b0011; ifa.ls_addr = 32'h40;
        ifa.ls_wdata = 32'hA5A5; ifa.ls_req = 1'b1;
        wait_for(1, tg);
        chk("t4_mem_we", {31'h0, ifa.mem_we}, 32'h1);
        chk("t4_mem_be", {28'h0, ifa.mem_be}, 32'h3);
        chk("t4_mem_wdata", ifa.mem_wdata, 32'hA5A5);
        step(); ifa.ls_req = 1'b0; ifa.ls_we = 1'b0;
        wait_for(3, tr);
        chk("t4_ls_rdata", ifa.ls_rdata, 32'h0);
        chk("t4_if_rvalid", {31'h0, ifa.if_rvalid}, 32'h0);

        // 5: reset during WAIT of a fetch
        step();
        ifa.if_addr = 32'h30; ifa.if_req = 1'b1;
        wait_for(0, tg);
        step(); ifa.if_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_if_rdata", ifa.if_rdata, 32'h0);
        chk("t5_rst_mem_be", {28'h0, ifa.mem_be}, 32'h0);
        step(); step(); rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ifa.if_rvalid) cnt++;
        end
        chk("t5_no_rvalid", cnt, 0);
        step();
        ifa.if_addr = 32'h34; ifa.if_req = 1'b1;
        wait_for(0, tg);
        step(); ifa.if_req = 1'b0;
        wait_for(2, tr);
        chk("t5_refetch_rdata", ifa.if_rdata, 32'h5A6EFFCB);

        // 6: MEM_LAT=3 back-to-back fetches on instance B
        step();
        ifb.if_addr = 32'h100; ifb.if_req = 1'b1;
        for (int n = 0; n < 3; n++) begin
            wait_for(4, g[n]);
            chk("t6_mem_addr", ifb.mem_addr, 32'h100 + 32'(4 * n));
            step();
            if (n < 2) ifb.if_addr = 32'h100 + 32'(4 * (n + 1));
            else       ifb.if_req = 1'b0;
        end
        repeat (8) step();
        chk("t6_rvalid_count", nrv, 3);
        for (int n = 0; n < 3; n++) begin
            chk("t6_rvalid_cycle", rvc[n], g[n] + 4);
            chk("t6_rdata", rvd[n], mem_word(32'h100 + 32'(4 * n)));
            if (n > 0) chk("t6_issue_spacing", g[n] - g[n-1], 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
